// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - shares one memory bus between the icache and the dcache
//
// Purpose: combinational grant of the single memory request port to the
// icache or the dcache, zero-latency return of the accepting response, and
// routing of returned data to whichever side issued the load that owns the
// returned tag. Returns for tags nobody owns are dropped and counted.
//
// Build option: MEM_ARB_RR_EN
//   defined   - round-robin between the two sides using a 1-bit preference
//   undefined - fixed priority, dcache over icache
//
// Ports:
//   clock, reset                      clock; synchronous active-high reset
//   ic2arb_command/addr               icache request (NONE or LOAD)
//   dc2arb_command/addr/data/size     dcache / victim-writeback request
//   arb2ic_response/data/tag          icache accept tag and data return
//   arb2dc_response/data/tag          dcache accept tag and data return
//   proc2mem_command/addr/data/size   request to memory
//   mem2proc_response/data/tag        memory accept tag and data return (0 = none)
//   orphan_cnt                        saturating count of unowned tag returns
module mem_bus_arbiter #(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [1:0]      ic2arb_command,
    input  logic [XLEN-1:0] ic2arb_addr,
    input  logic [1:0]      dc2arb_command,
    input  logic [XLEN-1:0] dc2arb_addr,
    input  logic [63:0]     dc2arb_data,
    input  logic [1:0]      dc2arb_size,
    output logic [3:0]      arb2ic_response,
    output logic [63:0]     arb2ic_data,
    output logic [3:0]      arb2ic_tag,
    output logic [3:0]      arb2dc_response,
    output logic [63:0]     arb2dc_data,
    output logic [3:0]      arb2dc_tag,
    output logic [1:0]      proc2mem_command,
    output logic [XLEN-1:0] proc2mem_addr,
    output logic [63:0]     proc2mem_data,
    output logic [1:0]      proc2mem_size,
    input  logic [3:0]      mem2proc_response,
    input  logic [63:0]     mem2proc_data,
    input  logic [3:0]      mem2proc_tag,
    output logic [7:0]      orphan_cnt
);

    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] SZ_DOUBLE = 2'd3;

    // Tag ownership table; entry 0 is never used because tag 0 means "none".
    logic [15:0] owner_valid;
    logic [15:0] owner_dc;        // 1 = dcache owns the tag, 0 = icache
    logic [15:0] owner_valid_next;
    logic [15:0] owner_dc_next;
    logic [7:0]  orphan_q;

    logic ic_req;
    logic dc_req;
    logic grant_ic;
    logic grant_dc;
    logic accepted;
    logic alloc;
    logic ret_valid;
    logic ret_hit;
    logic ret_orphan;

    // Requests are masked during reset so every output collapses to zero.
    assign ic_req   = !reset && (ic2arb_command != BUS_NONE);
    assign dc_req   = !reset && (dc2arb_command != BUS_NONE);
    assign accepted = (mem2proc_response != 4'd0);

`ifdef MEM_ARB_RR_EN
    logic pref_dc;                // side preferred when both request

    assign grant_dc = dc_req && (!ic_req || pref_dc);

    // The preference only moves once the preferred side actually got in;
    // a rejected attempt keeps its priority for the retry.
    always_ff @(posedge clock) begin
        if (reset) begin
            pref_dc <= 1'b1;
        end else if (accepted && ((pref_dc && grant_dc) || (!pref_dc && grant_ic))) begin
            pref_dc <= !pref_dc;
        end
    end
`else
    assign grant_dc = dc_req;
`endif

    assign grant_ic = ic_req && !grant_dc;

    assign alloc = accepted &&
                   ((grant_dc && (dc2arb_command == BUS_LOAD)) ||
                    (grant_ic && (ic2arb_command == BUS_LOAD)));

    assign ret_valid  = !reset && (mem2proc_tag != 4'd0);
    assign ret_hit    = ret_valid && owner_valid[mem2proc_tag];
    assign ret_orphan = ret_valid && !owner_valid[mem2proc_tag];

    // Request path to memory.
    always_comb begin
        proc2mem_command = BUS_NONE;
        proc2mem_addr    = '0;
        proc2mem_data    = '0;
        proc2mem_size    = 2'd0;
        if (grant_dc) begin
            proc2mem_command = dc2arb_command;
            proc2mem_addr    = dc2arb_addr;
            proc2mem_data    = dc2arb_data;
            proc2mem_size    = dc2arb_size;
        end else if (grant_ic) begin
            proc2mem_command = ic2arb_command;
            proc2mem_addr    = ic2arb_addr;
            proc2mem_size    = SZ_DOUBLE;
        end
    end

    // Response and data return paths.
    always_comb begin
        arb2ic_response = 4'd0;
        arb2dc_response = 4'd0;
        arb2ic_tag      = 4'd0;
        arb2ic_data     = 64'd0;
        arb2dc_tag      = 4'd0;
        arb2dc_data     = 64'd0;
        if (grant_dc) arb2dc_response = mem2proc_response;
        if (grant_ic) arb2ic_response = mem2proc_response;
        if (ret_hit) begin
            if (owner_dc[mem2proc_tag]) begin
                arb2dc_tag  = mem2proc_tag;
                arb2dc_data = mem2proc_data;
            end else begin
                arb2ic_tag  = mem2proc_tag;
                arb2ic_data = mem2proc_data;
            end
        end
    end

    // Retire before allocate so a tag reused in the same cycle stays live
    // under its new owner.
    always_comb begin
        owner_valid_next = owner_valid;
        owner_dc_next    = owner_dc;
        if (ret_hit) begin
            owner_valid_next[mem2proc_tag] = 1'b0;
        end
        if (alloc) begin
            owner_valid_next[mem2proc_response] = 1'b1;
            owner_dc_next[mem2proc_response]    = grant_dc;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            owner_valid <= '0;
            owner_dc    <= '0;
            orphan_q    <= 8'd0;
        end else begin
            owner_valid <= owner_valid_next;
            owner_dc    <= owner_dc_next;
            if (ret_orphan && (orphan_q != 8'hFF)) begin
                orphan_q <= orphan_q + 8'd1;
            end
        end
    end

    assign orphan_cnt = reset ? 8'd0 : orphan_q;

endmodule
